// File: rtl/xbar_slave_wrr_arbiter_if.sv
// xbar_slave_wrr_arbiter_if: master/slave bundle for one crossbar slave port (m_lock under XBAR_ARB_LOCK_EN)
interface xbar_slave_wrr_arbiter_if #(parameter int WIDTH = 32, parameter int WW = 4);
  logic [3:0]         m_req;
  logic [4*WIDTH-1:0] m_data;
  logic [3:0]         m_ack;
  logic               slave_req;
  logic [WIDTH-1:0]   slave_data;
  logic [1:0]         slave_mnum;
  logic               slave_ack;
  logic               cfg_we;
  logic [1:0]         cfg_mnum;
  logic [WW-1:0]      cfg_weight;
`ifdef XBAR_ARB_LOCK_EN
  logic [3:0]         m_lock;
`endif
  modport slave (
`ifdef XBAR_ARB_LOCK_EN
    input  m_lock,
`endif
    input  m_req, m_data, slave_ack, cfg_we, cfg_mnum, cfg_weight,
    output m_ack, slave_req, slave_data, slave_mnum
  );
  modport master (
`ifdef XBAR_ARB_LOCK_EN
    output m_lock,
`endif
    output m_req, m_data, slave_ack, cfg_we, cfg_mnum, cfg_weight,
    input  m_ack, slave_req, slave_data, slave_mnum
  );
endinterface

// File: rtl/xbar_slave_wrr_arbiter.sv
// xbar_slave_wrr_arbiter: registered weighted round-robin arbiter, 4 masters to 1 slave; XBAR_ARB_LOCK_EN adds m_lock
module xbar_slave_wrr_arbiter #(
  parameter int WIDTH = 32,
  parameter int WW    = 4
) (
  input logic clk_i,
  input logic rst_i,
  xbar_slave_wrr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [1:0] rr_ptr, grant, sel;
  logic [WW-1:0] credit, wt_sel, wt_g;
  logic [WW-1:0] weight [4];
  logic act, req_g, hs, lock_g, last;
`ifdef XBAR_ARB_LOCK_EN
  assign lock_g = bus.m_lock[grant];
`else
  assign lock_g = 1'b0;
`endif
  // outputs are forced low while reset is held so a mid-burst reset never acks
  assign act    = (state == BUSY) & ~rst_i;
  assign req_g  = bus.m_req[grant];
  assign hs     = act & req_g & bus.slave_ack;
  assign last   = credit == WW'(1);
  assign wt_sel = (weight[sel] == '0) ? WW'(1) : weight[sel];
  assign wt_g   = (weight[grant] == '0) ? WW'(1) : weight[grant];
  always_comb begin
    sel = rr_ptr;
    for (int k = 3; k >= 0; k--)
      if (bus.m_req[2'(rr_ptr + 2'(k))]) sel = 2'(rr_ptr + 2'(k));
  end
  always_comb begin
    state_nx = (state == IDLE) ? (|bus.m_req ? BUSY : IDLE)
             : (!req_g || (hs && last && !lock_g)) ? IDLE : BUSY;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      credit <= '0;
      for (int i = 0; i < 4; i++) weight[i] <= WW'(1);
    end else begin
      state <= state_nx;
      if (bus.cfg_we) weight[bus.cfg_mnum] <= bus.cfg_weight;
      if (state == IDLE && |bus.m_req) begin
        grant  <= sel;
        credit <= wt_sel;
      end
      if (state == BUSY && state_nx == IDLE) rr_ptr <= grant + 2'd1;
      if (hs) credit <= !last ? credit - WW'(1) : lock_g ? wt_g : credit;
    end
  end
  always_comb begin
    bus.slave_req  = act & req_g;
    bus.slave_data = act ? bus.m_data[32'(grant)*WIDTH +: WIDTH] : '0;
    bus.slave_mnum = act ? grant : 2'd0;
    bus.m_ack      = hs ? 4'(4'b0001 << grant) : 4'b0000;
  end
endmodule
